// File: rtl/snn_aer_pkg.sv
// Shared AER link definitions: handshake FSM encoding, default widths and the event record,
// common to this encoder and the off-core AER receiver.
package snn_aer_pkg;

  localparam int ADDR_WIDTH_DEF = 2;
  localparam int TS_WIDTH_DEF   = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [TS_WIDTH_DEF-1:0]   ts;
  } aer_event_t;

  // Number of set bits; spike vectors are at most 16 lines wide.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Single-clock event queue with full/empty/level. A push while full is refused even when a
// pop happens in the same cycle.
module aer_event_fifo
  import snn_aer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign level     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/snn_aer_spike_encoder.sv
// AER transmitter: latches neuron spikes, arbitrates round-robin into an event queue and sends
// each event over a 4-phase req/ack link. Define AER_TIMESTAMP_EN to attach a grant-time stamp.
module snn_aer_spike_encoder
  import snn_aer_pkg::*;
#(
  parameter int NUM_NEURONS = 3,
  parameter int ADDR_WIDTH  = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 16,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_NEURONS-1:0]        spike_in,
  output logic                          aer_req,
  output logic [ADDR_WIDTH-1:0]         aer_addr,
  output logic [TS_WIDTH-1:0]           aer_ts,
  input  logic                          aer_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_WIDTH-1:0]         drop_count,
  output logic                          busy
);

`ifdef AER_TIMESTAMP_EN
  localparam int ENTRY_W = ADDR_WIDTH + TS_WIDTH;
`else
  localparam int ENTRY_W = ADDR_WIDTH;
`endif
  localparam int SUM_W = DROP_WIDTH + 5;

  logic                   ack_s1_q, ack_s_q;
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [NUM_NEURONS-1:0] grant_oh_s, drop_vec_s;
  logic [ADDR_WIDTH-1:0]  rr_q, rr_d, grant_idx_s;
  logic                   grant_s;
  logic [DROP_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic [SUM_W-1:0]       drop_sum_s;
  logic [1:0]             state_q, state_d;
  logic                   aer_req_q, aer_req_d;
  logic [ADDR_WIDTH-1:0]  aer_addr_q, aer_addr_d;
  logic                   fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic [ENTRY_W-1:0]     fifo_wdata_s, fifo_rdata_s;

  // First pending line at or after the rr pointer wins; nothing is granted while the queue is full.
  always_comb begin
    int idx;
    idx         = 0;
    grant_s     = 1'b0;
    grant_idx_s = {ADDR_WIDTH{1'b0}};
    grant_oh_s  = {NUM_NEURONS{1'b0}};
    rr_d        = rr_q;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      idx = (int'(rr_q) + k) % NUM_NEURONS;
      if (!grant_s && pending_q[idx] && !fifo_full_s) begin
        grant_s         = 1'b1;
        grant_idx_s     = ADDR_WIDTH'(idx);
        grant_oh_s[idx] = 1'b1;
        rr_d            = ADDR_WIDTH'((idx + 1) % NUM_NEURONS);
      end else begin
        grant_oh_s = grant_oh_s;
      end
    end
  end

  // A new spike on a line that keeps its pending bit is lost; a spike in the grant cycle re-arms it.
  always_comb begin
    pending_d  = (pending_q & ~grant_oh_s) | spike_in;
    drop_vec_s = spike_in & pending_q & ~grant_oh_s;
    drop_sum_s = SUM_W'(drop_count_q) + SUM_W'(popcount16(16'(drop_vec_s)));
    if (drop_sum_s > SUM_W'({DROP_WIDTH{1'b1}})) begin
      drop_count_d = {DROP_WIDTH{1'b1}};
    end else begin
      drop_count_d = drop_sum_s[DROP_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    aer_req_d  = aer_req_q;
    aer_addr_d = aer_addr_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s && !ack_s_q) begin
          fifo_pop_s = 1'b1;
          aer_req_d  = 1'b1;
          aer_addr_d = fifo_rdata_s[ENTRY_W-1 -: ADDR_WIDTH];
          state_d    = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_s_q) begin
          aer_req_d = 1'b0;
          state_d   = ST_RELEASE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RELEASE: begin
        if (!ack_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        aer_req_d = 1'b0;
      end
    endcase
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_WIDTH-1:0] aer_ts_q, aer_ts_d;

  always_comb begin
    ts_cnt_d = ts_cnt_q + 1'b1;
    if (fifo_pop_s) begin
      aer_ts_d = fifo_rdata_s[TS_WIDTH-1:0];
    end else begin
      aer_ts_d = aer_ts_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q <= {TS_WIDTH{1'b0}};
      aer_ts_q <= {TS_WIDTH{1'b0}};
    end else begin
      ts_cnt_q <= ts_cnt_d;
      aer_ts_q <= aer_ts_d;
    end
  end

  assign fifo_wdata_s = {grant_idx_s, ts_cnt_q};
  assign aer_ts       = aer_ts_q;
`else
  assign fifo_wdata_s = grant_idx_s;
  assign aer_ts       = {TS_WIDTH{1'b0}};
`endif

  aer_event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_s),
    .pop   (fifo_pop_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_s1_q     <= 1'b0;
      ack_s_q      <= 1'b0;
      pending_q    <= {NUM_NEURONS{1'b0}};
      rr_q         <= {ADDR_WIDTH{1'b0}};
      drop_count_q <= {DROP_WIDTH{1'b0}};
      state_q      <= ST_IDLE;
      aer_req_q    <= 1'b0;
      aer_addr_q   <= {ADDR_WIDTH{1'b0}};
    end else begin
      ack_s1_q     <= aer_ack;
      ack_s_q      <= ack_s1_q;
      pending_q    <= pending_d;
      rr_q         <= rr_d;
      drop_count_q <= drop_count_d;
      state_q      <= state_d;
      aer_req_q    <= aer_req_d;
      aer_addr_q   <= aer_addr_d;
    end
  end

  assign aer_req    = aer_req_q;
  assign aer_addr   = aer_addr_q;
  assign drop_count = drop_count_q;
  assign busy       = (|pending_q) | ~fifo_empty_s | (state_q != ST_IDLE);

endmodule

// File: tb/tb_snn_aer_spike_encoder.sv
// Directed bench for snn_aer_spike_encoder with a behavioural AER receiver that logs events.
module tb_snn_aer_spike_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] spike_in;
  logic       aer_req;
  logic [1:0] aer_addr;
  logic [3:0] aer_ts;
  logic       aer_ack;
  logic [3:0] fifo_level;
  logic [7:0] drop_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic       rx_en;
  int         ack_delay;
  int         rx_cnt;
  logic [1:0] ev_addr [$];
  logic [3:0] ev_ts   [$];

  snn_aer_spike_encoder #(
    .NUM_NEURONS (3),
    .ADDR_WIDTH  (2),
    .FIFO_DEPTH  (8),
    .TS_WIDTH    (4),
    .DROP_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .aer_req    (aer_req),
    .aer_addr   (aer_addr),
    .aer_ts     (aer_ts),
    .aer_ack    (aer_ack),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Receiver: logs each new request, raises ack after a delay when enabled, releases when req drops.
  initial begin
    aer_ack = 1'b0;
    rx_cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aer_ack = 1'b0;
        rx_cnt  = 0;
      end else if (aer_req && !aer_ack) begin
        if (rx_cnt == 0) begin
          ev_addr.push_back(aer_addr);
          ev_ts.push_back(aer_ts);
          rx_cnt = 1;
        end else if (rx_en) begin
          rx_cnt++;
          if (rx_cnt >= ack_delay) aer_ack = 1'b1;
        end
      end else if (!aer_req && aer_ack) begin
        aer_ack = 1'b0;
        rx_cnt  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst       = 1'b1;
    spike_in  = 3'b000;
    rx_en     = 1'b1;
    ack_delay = 3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ev_addr.delete();
    ev_ts.delete();
  endtask

  task automatic pulse(input logic [2:0] v);
    spike_in = v;
    @(posedge clk);
    @(negedge clk);
    spike_in = 3'b000;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && !aer_req && !aer_ack) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; spike_in = 3'b000; rx_en = 1'b1; ack_delay = 3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (aer_req !== 1'b0)    begin errors++; $display("FAIL reset_req got %0b want 0", aer_req); end
    checks++; if (aer_addr !== 2'd0)   begin errors++; $display("FAIL reset_addr got %0d want 0", aer_addr); end
    checks++; if (aer_ts !== 4'd0)     begin errors++; $display("FAIL reset_ts got %0d want 0", aer_ts); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    repeat (9) @(negedge clk);
    spike_in = 3'b010;
    @(posedge clk);
    @(negedge clk);
    spike_in = 3'b000;
    checks++; if (aer_req !== 1'b0) begin errors++; $display("FAIL single_req_t got %0b want 0", aer_req); end
    @(posedge clk); @(negedge clk);
    checks++; if (aer_req !== 1'b0) begin errors++; $display("FAIL single_req_t1 got %0b want 0", aer_req); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL single_level_t1 got %0d want 1", fifo_level); end
    @(posedge clk); @(negedge clk);
    checks++; if (aer_req !== 1'b1) begin errors++; $display("FAIL single_req_t2 got %0b want 1", aer_req); end
    checks++; if (aer_addr !== 2'd1) begin errors++; $display("FAIL single_addr got %0d want 1", aer_addr); end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle got busy want idle"); end
    checks++; if (ev_addr.size() != 1) begin errors++; $display("FAIL single_events got %0d want 1", ev_addr.size()); end
    else begin
      checks++; if (ev_addr[0] !== 2'd1) begin errors++; $display("FAIL single_ev_addr got %0d want 1", ev_addr[0]); end
    end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL single_drop got %0d want 0", drop_count); end
  endtask

  task automatic test_all_lines();
    bit ok;
    do_reset();
    pulse(3'b111);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL all_idle got busy want idle"); end
    checks++; if (ev_addr.size() != 3) begin errors++; $display("FAIL all_events got %0d want 3", ev_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_addr[i] !== 2'(i)) begin errors++; $display("FAIL all_order[%0d] got %0d want %0d", i, ev_addr[i], i); end
      end
    end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL all_drop got %0d want 0", drop_count); end
  endtask

  task automatic test_fifo_full_drops();
    do_reset();
    rx_en = 1'b0;
    for (int k = 0; k < 11; k++) pulse((k % 2 == 0) ? 3'b001 : 3'b100);
    repeat (2) @(negedge clk);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level got %0d want 8", fifo_level); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL full_nodrop got %0d want 0", drop_count); end
    checks++; if (aer_req !== 1'b1 || aer_addr !== 2'd0) begin errors++; $display("FAIL full_req got req=%0b addr=%0d want req=1 addr=0", aer_req, aer_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %0b want 1", busy); end
    repeat (3) pulse(3'b001);
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL drop_three got %0d want 3", drop_count); end
    pulse(3'b101);
    checks++; if (drop_count !== 8'd5) begin errors++; $display("FAIL drop_pair got %0d want 5", drop_count); end
    for (int k = 0; k < 130; k++) pulse(3'b101);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_count); end
    pulse(3'b001);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_hold got %0d want 255", drop_count); end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level_end got %0d want 8", fifo_level); end
    checks++; if (ev_addr.size() != 1) begin errors++; $display("FAIL full_events got %0d want 1", ev_addr.size()); end
  endtask

  task automatic test_same_cycle();
    bit ok;
    do_reset();
    pulse(3'b001);
    pulse(3'b001);
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL same_drop got %0d want 0", drop_count); end
    wait_idle(80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL same_idle got busy want idle"); end
    checks++; if (ev_addr.size() != 2) begin errors++; $display("FAIL same_events got %0d want 2", ev_addr.size()); end
    else begin
      checks++; if (ev_addr[0] !== 2'd0 || ev_addr[1] !== 2'd0) begin errors++; $display("FAIL same_addr got %0d,%0d want 0,0", ev_addr[0], ev_addr[1]); end
    end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL same_drop_end got %0d want 0", drop_count); end
  endtask

  task automatic test_reset_mid();
    int req_seen;
    do_reset();
    rx_en = 1'b0;
    for (int k = 0; k < 5; k++) pulse((k % 2 == 0) ? 3'b001 : 3'b100);
    repeat (3) @(negedge clk);
    checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL mid_level got %0d want 4", fifo_level); end
    checks++; if (aer_req !== 1'b1) begin errors++; $display("FAIL mid_req got %0b want 1", aer_req); end
    rst = 1'b1;
    #1;
    checks++; if (aer_req !== 1'b0) begin errors++; $display("FAIL mid_async_req got %0b want 0", aer_req); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL mid_async_level got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %0b want 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx_en = 1'b1;
    ev_addr.delete();
    ev_ts.delete();
    req_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (aer_req) req_seen++;
    end
    checks++; if (req_seen != 0 || ev_addr.size() != 0) begin errors++; $display("FAIL mid_after got req_cycles=%0d events=%0d want 0,0", req_seen, ev_addr.size()); end
  endtask

  task automatic test_timestamp();
    bit ok;
    logic [3:0] diff;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      pulse(3'b010);
      repeat (19) @(negedge clk);
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ts_idle got busy want idle"); end
    checks++; if (ev_ts.size() != 3) begin errors++; $display("FAIL ts_events got %0d want 3", ev_ts.size()); end
    else begin
      for (int i = 1; i < 3; i++) begin
`ifdef AER_TIMESTAMP_EN
        diff = ev_ts[i] - ev_ts[i-1];
        checks++; if (diff !== 4'd4) begin errors++; $display("FAIL ts_diff[%0d] got %0d want 4", i, diff); end
`else
        diff = ev_ts[i] | ev_ts[i-1];
        checks++; if (diff !== 4'd0) begin errors++; $display("FAIL ts_zero[%0d] got %0d want 0", i, diff); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_lines();
    test_fifo_full_drops();
    test_same_cycle();
    test_reset_mid();
    test_timestamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
